spi_cs_sequencer: RTL and testbench

Transaction sequencer sitting directly upstream of the SPI master byte engine. It accepts multi-byte transfer commands and buffers outgoing bytes in a small TX FIFO. It issues bytes one at a time over the master's tx_byte/tx_vld/ready handshake and captures each returned RX byte. It also owns chip-select, including setup, hold and minimum-deassert timing, which the master does not generate.

---
 rtl/spi_pkg.sv | 5 +
 rtl/spi_tx_fifo.sv | 34 +++
 rtl/spi_cs_sequencer.sv | 123 ++++++++++++
 tb/tb_spi_cs_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and default byte width shared by the SPI master and its sequencer
package spi_pkg;
  localparam int SPI_BUS = 8;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD, GAP} seq_state_t;
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: circular TX byte buffer with one extra pointer bit to tell full from empty
module spi_tx_fifo #(
  parameter int BUS = 8,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           push,
  input  logic [BUS-1:0] din,
  input  logic           pop,
  output logic [BUS-1:0] dout,
  output logic           full,
  output logic           empty
);
  localparam int AW = $clog2(DEPTH);
  logic [BUS-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer: feeds buffered bytes to the SPI master one at a time and owns chip-select timing
module spi_cs_sequencer
  import spi_pkg::*;
#(
  parameter int BUS = SPI_BUS,
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2,
  parameter int CS_IDLE = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_vld,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_rdy,
  input  logic [BUS-1:0]   wr_data,
  input  logic             wr_vld,
  output logic             wr_rdy,
  output logic [BUS-1:0]   rd_data,
  output logic             rd_vld,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic [BUS-1:0]   m_tx_byte,
  output logic             m_tx_vld,
  input  logic             m_ready,
  input  logic [BUS-1:0]   m_rx_byte
);
  localparam int CMAX = CS_SETUP > CS_HOLD ? (CS_SETUP > CS_IDLE ? CS_SETUP : CS_IDLE)
                                           : (CS_HOLD > CS_IDLE ? CS_HOLD : CS_IDLE);
  localparam int CNT_W = $clog2(CMAX + 1);
  seq_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [LEN_W-1:0] rem, rem_d;
  logic [BUS-1:0] head, tx_byte_d, rd_data_d;
  logic seen, seen_d, cs_n_d, tx_vld_d, rd_vld_d, done_d, full, empty, setup_end, issue;
  spi_tx_fifo #(.BUS(BUS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .arst_n(arst_n), .push(wr_vld), .din(wr_data),
    .pop(issue), .dout(head), .full(full), .empty(empty)
  );
  assign cmd_rdy = state == IDLE;
  assign busy = !cmd_rdy;
  assign wr_rdy = !full;
  assign setup_end = state == SETUP && cnt == CNT_W'(CS_SETUP - 1);
  // The last setup cycle may already issue so the first byte lands exactly CS_SETUP after cs_n falls
  assign issue = !empty && m_ready && (state == ISSUE || setup_end);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    rem_d = rem;
    seen_d = issue ? 1'b0 : seen;
    cs_n_d = cs_n;
    tx_vld_d = issue;
    tx_byte_d = issue ? head : m_tx_byte;
    rd_data_d = rd_data;
    rd_vld_d = 1'b0;
    done_d = 1'b0;
    case (state)
      IDLE: if (cmd_vld) begin
        state_d = SETUP;
        rem_d = cmd_len;
        cs_n_d = 1'b0;
        cnt_d = '0;
      end
      SETUP: begin
        cnt_d = cnt + CNT_W'(1);
        if (setup_end) state_d = issue ? WAIT : ISSUE;
      end
      ISSUE: if (issue) state_d = WAIT;
      WAIT: begin
        if (!m_ready) seen_d = 1'b1;
        if (seen && m_ready) begin
          rd_data_d = m_rx_byte;
          rd_vld_d = 1'b1;
          cnt_d = '0;
          state_d = rem == '0 ? HOLD : ISSUE;
          rem_d = rem == '0 ? rem : rem - LEN_W'(1);
        end
      end
      HOLD: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d = 1'b1;
          cnt_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CS_IDLE - 1)) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      seen <= 1'b0;
      cs_n <= 1'b1;
      m_tx_vld <= 1'b0;
      m_tx_byte <= '0;
      rd_data <= '0;
      rd_vld <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rem <= rem_d;
      seen <= seen_d;
      cs_n <= cs_n_d;
      m_tx_vld <= tx_vld_d;
      m_tx_byte <= tx_byte_d;
      rd_data <= rd_data_d;
      rd_vld <= rd_vld_d;
      done <= done_d;
    end
endmodule

// File: tb/tb_spi_cs_sequencer.sv
// tb_spi_cs_sequencer: randomized scoreboard bench with a loopback SPI master model
module tb_spi_cs_sequencer;
  localparam int BUS = 8, DEPTH = 8, LEN_W = 8, CS_SETUP = 2, CS_HOLD = 2, CS_IDLE = 2;
  logic clk = 0, arst_n = 0, cmd_vld = 0, wr_vld = 0, m_ready = 1;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [BUS-1:0] wr_data = '0, m_rx_byte = '0;
  logic cmd_rdy, wr_rdy, rd_vld, busy, done, cs_n, m_tx_vld;
  logic [BUS-1:0] rd_data, m_tx_byte;
  always #5 clk = ~clk;
  spi_cs_sequencer #(.BUS(BUS), .DEPTH(DEPTH), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP),
                     .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .arst_n(arst_n), .cmd_vld(cmd_vld), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .rd_data(rd_data), .rd_vld(rd_vld),
    .busy(busy), .done(done), .cs_n(cs_n), .m_tx_byte(m_tx_byte), .m_tx_vld(m_tx_vld),
    .m_ready(m_ready), .m_rx_byte(m_rx_byte)
  );
  int cyc = 0, total = 0, passed = 0, tx_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [7:0] exp_tx[$], exp_rx[$];
  int exp_len[$];
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endfunction
  always @(posedge clk) cyc++;
  // Master model: busy for a random few cycles after each tx_vld, then returns the byte on MISO
  initial begin
    int mb;
    logic [7:0] cap;
    mb = 0;
    cap = '0;
    forever begin
      @(posedge clk); #1;
      if (!arst_n) begin
        m_ready = 1;
        mb = 0;
      end else if (m_ready && m_tx_vld) begin
        cap = m_tx_byte;
        m_ready = 0;
        mb = $urandom_range(1, 4);
      end else if (!m_ready) begin
        if (mb == 0) begin
          m_ready = 1;
          m_rx_byte = cap;
        end else mb--;
      end
    end
  end
  // Monitor: every DUT event is checked against expectations queued when stimulus was accepted
  int acc_cyc = -100, avail_cyc = -1, rise_cyc = -100, last_rd_cyc = -100, nbytes = 0;
  bit active = 0, first_pend = 0, prev_cs = 1, prev_tx = 0;
  always @(negedge clk) begin
    if (!arst_n) begin
      exp_tx.delete(); exp_rx.delete(); exp_len.delete();
      active = 0; first_pend = 0; prev_cs = 1; prev_tx = 0; nbytes = 0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, rise_cyc + CS_IDLE);
        if (exp_len.size() == 0) chk("done_unexpected", 1, 0);
        else chk("bytes_per_cmd", nbytes, exp_len.pop_front());
        nbytes = 0;
        active = 0;
      end
      chk("busy", busy, active);
      chk("cmd_rdy", cmd_rdy, !active);
      if (m_tx_vld) begin
        tx_cnt++;
        chk("tx_cs_low", cs_n, 0);
        chk("tx_single_cycle", prev_tx, 0);
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_byte", m_tx_byte, exp_tx.pop_front());
        if (first_pend) begin
          first_pend = 0;
          chk("first_tx_latency", cyc, (acc_cyc + CS_SETUP + 1 > avail_cyc + 2) ?
                                       acc_cyc + CS_SETUP + 1 : avail_cyc + 2);
        end
      end
      prev_tx = m_tx_vld;
      if (rd_vld) begin
        rd_cnt++;
        nbytes++;
        last_rd_cyc = cyc;
        chk("rd_cs_low", cs_n, 0);
        if (exp_rx.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, exp_rx.pop_front());
      end
      if (cs_n != prev_cs) begin
        if (!cs_n) begin
          chk("cs_fall", cyc, acc_cyc + 1);
          chk("cs_gap", (cyc - rise_cyc) >= CS_IDLE, 1);
        end else begin
          chk("cs_rise", cyc, last_rd_cyc + CS_HOLD);
          rise_cyc = cyc;
        end
      end
      prev_cs = cs_n;
      chk("wr_rdy", wr_rdy, exp_tx.size() < DEPTH);
      if (cmd_vld && cmd_rdy) begin
        acc_cyc = cyc;
        active = 1;
        first_pend = 1;
        exp_len.push_back(int'(cmd_len) + 1);
        avail_cyc = exp_tx.size() > 0 ? cyc : -1;
      end
      if (wr_vld && wr_rdy) begin
        exp_tx.push_back(wr_data);
        exp_rx.push_back(wr_data);
        if (first_pend && avail_cyc < 0) avail_cyc = cyc;
      end
    end
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic write_byte(input logic [7:0] b);
    bit ok;
    int k;
    k = 0;
    wr_data = b;
    wr_vld = 1;
    do begin
      @(negedge clk);
      ok = wr_rdy;
      tick();
      k++;
    end while (!ok && k < 500);
    wr_vld = 0;
    chk("write_accepted", ok, 1);
  endtask
  task automatic send_cmd(input int len);
    bit ok;
    int k;
    k = 0;
    cmd_len = LEN_W'(len);
    cmd_vld = 1;
    do begin
      @(negedge clk);
      ok = cmd_rdy;
      tick();
      k++;
    end while (!ok && k < 500);
    cmd_vld = 0;
    chk("cmd_accepted", ok, 1);
  endtask
  task automatic wait_done(input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt != start, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int base, n, k, len, pre;
    #12;
    chk("rst_cs_n", cs_n, 1); chk("rst_tx_vld", m_tx_vld, 0); chk("rst_tx_byte", m_tx_byte, 0);
    chk("rst_rd_vld", rd_vld, 0); chk("rst_rd_data", rd_data, 0); chk("rst_done", done, 0);
    chk("rst_busy", busy, 0); chk("rst_cmd_rdy", cmd_rdy, 1); chk("rst_wr_rdy", wr_rdy, 1);
    tick(); arst_n = 1; tick(); tick();
    // Pre-filled two-byte command
    base = rd_cnt;
    write_byte(8'hA5); write_byte(8'h3C);
    send_cmd(1);
    wait_done(200);
    chk("t1_rd_count", rd_cnt - base, 2);
    // Underrun stall: command first, bytes much later
    base = tx_cnt;
    send_cmd(2);
    repeat (20) tick();
    chk("stall_no_tx", tx_cnt, base);
    chk("stall_cs_low", cs_n, 0);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    wait_done(200);
    chk("stall_transfers", tx_cnt - base, 3);
    // Overfill while idle; the ninth byte waits for the first pop and wraps the pointer
    base = rd_cnt;
    for (int i = 0; i < DEPTH; i++) write_byte(8'h80 + 8'(i));
    @(negedge clk);
    chk("full_wr_rdy", wr_rdy, 0);
    tick();
    fork
      write_byte(8'h5E);
      begin repeat (3) tick(); send_cmd(DEPTH); end
    join
    wait_done(400);
    chk("wrap_rd_count", rd_cnt - base, DEPTH + 1);
    // Reset during the WAIT of byte 2 of 4
    base = tx_cnt;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    send_cmd(3);
    k = 0;
    while (tx_cnt < base + 2 && k < 200) begin tick(); k++; end
    chk("second_tx_seen", tx_cnt - base, 2);
    @(posedge clk); #3;
    arst_n = 0;
    #1;
    chk("arst_cs_n", cs_n, 1); chk("arst_tx_vld", m_tx_vld, 0); chk("arst_tx_byte", m_tx_byte, 0);
    chk("arst_rd_vld", rd_vld, 0); chk("arst_rd_data", rd_data, 0); chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    tick(); tick(); tick();
    arst_n = 1;
    @(negedge clk);
    chk("post_rst_cmd_rdy", cmd_rdy, 1);
    chk("post_rst_wr_rdy", wr_rdy, 1);
    tick();
    write_byte(8'h77);
    send_cmd(0);
    wait_done(200);
    // Back-to-back single-byte commands with cmd_vld held high
    write_byte(8'hC1); write_byte(8'hC2);
    cmd_len = '0;
    cmd_vld = 1;
    n = 0;
    k = 0;
    while (n < 2 && k < 300) begin
      @(negedge clk);
      if (cmd_rdy) n++;
      tick();
      k++;
    end
    cmd_vld = 0;
    chk("b2b_accepts", n, 2);
    wait_done(200);
    // Random commands with partial pre-fill
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(0, 5);
      pre = $urandom_range(0, len + 1);
      for (int j = 0; j < pre; j++) write_byte(8'($urandom));
      fork
        send_cmd(len);
        for (int j = pre; j <= len; j++) write_byte(8'($urandom));
      join
      wait_done(300);
    end
    // Maximum-length command
    base = rd_cnt;
    n = done_cnt;
    fork
      send_cmd(255);
      for (int j = 0; j < 256; j++) write_byte(8'($urandom));
    join
    wait_done(5000);
    chk("max_rd_count", rd_cnt - base, 256);
    repeat (10) tick();
    chk("max_single_done", done_cnt - n, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
